cmos_oai: RTL and testbench

- 2-2 OR-AND-INVERT (OAI22) cell: f53 = ~((a | b) & (c | d)).
- Modelled at CMOS switch level, with a registered copy of the output and a self-check flag.
- Used as a library/teaching leaf cell.
- f53 is purely combinational, so a clockless bench can drive a..d and sample f53 directly.

---
 rtl/cmos_oai_pkg.sv | 18 +
 rtl/cmos_oai_core.sv | 40 ++++
 rtl/cmos_oai.sv | 72 +++++++
 tb/tb_cmos_oai.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cmos_oai_pkg.sv
// ---------------------------------------------------------------------------
// cmos_oai_pkg
// Shared constants and the gate-level OAI22 reference used by the cmos_oai
// cell for its self-check.
//   OAI_RESET_VAL : value f53_q takes under reset (OAI of all-zero inputs)
//   oai22_ref()   : ~((a | b) & (c | d)) with ordinary 4-state operators,
//                   so inputs of 0,0 in either OR group still force a 1
// ---------------------------------------------------------------------------
package cmos_oai_pkg;

   localparam logic OAI_RESET_VAL = 1'b1;

   function automatic logic oai22_ref(input logic a, input logic b,
                                      input logic c, input logic d);
      return ~((a | b) & (c | d));
   endfunction

endpackage : cmos_oai_pkg

// File: rtl/cmos_oai_core.sv
// ---------------------------------------------------------------------------
// cmos_oai_core
// Eight-transistor CMOS OAI22 network, y = ~((a | b) & (c | d)).
//   a, b : OR-group-1 gate inputs
//   c, d : OR-group-2 gate inputs
//   y    : output node (net, resolved from the two networks)
// Pull-up  : (p_a series p_b) parallel (p_c series p_d), vdd -> y
// Pull-down: (n_a parallel n_b) series (n_c parallel n_d), y -> gnd
// For any fully-known input exactly one network conducts, so y is never
// floating and never contended. Unknown gates give x unless the other
// network is fully off and the conducting one is fully on.
// ---------------------------------------------------------------------------
module cmos_oai_core (
   input  logic a,
   input  logic b,
   input  logic c,
   input  logic d,
   output wire  y
);

   supply1 vdd;
   supply0 gnd;

   wire pu_ab;   // node between the series a/b pmos pair
   wire pu_cd;   // node between the series c/d pmos pair
   wire pd_mid;  // node between the two parallel nmos pairs

   // pull-up network: a conducting pmos has its gate at 0
   pmos p_a (pu_ab, vdd,   a);
   pmos p_b (y,     pu_ab, b);
   pmos p_c (pu_cd, vdd,   c);
   pmos p_d (y,     pu_cd, d);

   // pull-down network
   nmos n_a (y,      pd_mid, a);
   nmos n_b (y,      pd_mid, b);
   nmos n_c (pd_mid, gnd,    c);
   nmos n_d (pd_mid, gnd,    d);

endmodule : cmos_oai_core

// File: rtl/cmos_oai.sv
// ---------------------------------------------------------------------------
// cmos_oai
// OAI22 leaf cell with a registered copy of the output and a self-check flag
// comparing the selected implementation against the gate-level expression.
//   clk     : rising-edge clock for f53_q and chk_err
//   rst     : asynchronous, active-high reset
//   a, b    : OR-group-1 inputs
//   c, d    : OR-group-2 inputs
//   f53     : combinational OAI22 result (independent of clk/rst)
//   f53_q   : f53 registered on clk, resets to 1
//   chk_err : registered mismatch flag, resets to 0
// Parameters:
//   USE_SWITCH : 1 = f53 from the transistor network, 0 = from the expression
//   ERR_STICKY : 1 = chk_err holds once set until reset, 0 = per-cycle flag
// ---------------------------------------------------------------------------
module cmos_oai
   import cmos_oai_pkg::*;
#(
   parameter bit USE_SWITCH = 1'b1,
   parameter bit ERR_STICKY = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic a,
   input  logic b,
   input  logic c,
   input  logic d,
   output logic f53,
   output logic f53_q,
   output logic chk_err
);

   logic f53_ref;
   logic inputs_known;
   logic mismatch;

   assign f53_ref = oai22_ref(a, b, c, d);

   generate
      if (USE_SWITCH) begin : g_switch
         wire y_sw;
         cmos_oai_core u_core (
            .a (a),
            .b (b),
            .c (c),
            .d (d),
            .y (y_sw)
         );
         assign f53 = y_sw;
      end else begin : g_gate
         assign f53 = f53_ref;
      end
   endgenerate

   // The comparison is only meaningful when every input is a clean 0/1; an
   // x input legitimately leaves both f53 and f53_ref partly unknown.
   assign inputs_known = !$isunknown({a, b, c, d});
   assign mismatch     = inputs_known && (f53 !== f53_ref);

   // NOTE: registers are written with <= so every flop samples the values
   // present before the edge, independent of block evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         f53_q   <= OAI_RESET_VAL;
         chk_err <= 1'b0;
      end else begin
         f53_q   <= f53;
         chk_err <= mismatch | (ERR_STICKY & chk_err);
      end
   end

endmodule : cmos_oai

// File: tb/tb_cmos_oai.sv
// ---------------------------------------------------------------------------
// tb_cmos_oai
// Drives two cmos_oai instances in parallel: the switch-level build with a
// sticky error flag, and the gate-level build with a per-cycle error flag.
// Expected values come from the OAI22 truth table expressed as the set of
// input codes that give 0.
// ---------------------------------------------------------------------------
module tb_cmos_oai;

   logic clk;
   logic rst;
   logic a, b, c, d;

   logic f53_s, f53_q_s, chk_err_s;
   logic f53_g, f53_q_g, chk_err_g;

   int checks   = 0;
   int failures = 0;

   // abcd codes for which the cell output is 0; all others give 1
   logic [3:0] zero_codes [9] = '{4'b0101, 4'b0110, 4'b0111,
                                  4'b1001, 4'b1010, 4'b1011,
                                  4'b1101, 4'b1110, 4'b1111};

   cmos_oai #(.USE_SWITCH(1'b1), .ERR_STICKY(1'b1)) dut_sw (
      .clk     (clk),
      .rst     (rst),
      .a       (a),
      .b       (b),
      .c       (c),
      .d       (d),
      .f53     (f53_s),
      .f53_q   (f53_q_s),
      .chk_err (chk_err_s)
   );

   cmos_oai #(.USE_SWITCH(1'b0), .ERR_STICKY(1'b0)) dut_gt (
      .clk     (clk),
      .rst     (rst),
      .a       (a),
      .b       (b),
      .c       (c),
      .d       (d),
      .f53     (f53_g),
      .f53_q   (f53_q_g),
      .chk_err (chk_err_g)
   );

   function automatic logic model_oai(input logic [3:0] code);
      foreach (zero_codes[i])
         if (zero_codes[i] == code) return 1'b0;
      return 1'b1;
   endfunction

   task automatic drive(input logic [3:0] code);
      {a, b, c, d} = code;
   endtask

   // one full clock period: rising edge at +5, falling edge at +10
   task automatic tick();
      #5 clk = 1'b1;
      #5 clk = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(4'b1111);
      #1;
      if ({f53_q_s, f53_q_g} !== 2'b11) begin
         failures++;
         $display("FAIL reset_f53_q: got %b%b want 11", f53_q_s, f53_q_g);
      end
      checks++;
      if ({chk_err_s, chk_err_g} !== 2'b00) begin
         failures++;
         $display("FAIL reset_chk_err: got %b%b want 00", chk_err_s, chk_err_g);
      end
      checks++;
      if ({f53_s, f53_g} !== 2'b00) begin
         failures++;
         $display("FAIL reset_f53: got %b%b want 00", f53_s, f53_g);
      end
      checks++;
      tick();
      if ({f53_q_s, f53_q_g, f53_s} !== 3'b110) begin
         failures++;
         $display("FAIL reset_held: f53_q=%b%b f53=%b want 11/0", f53_q_s, f53_q_g, f53_s);
      end
      checks++;
   endtask

   // clock idle: f53 must follow the inputs with no edge at all
   task automatic test_sweep();
      logic [15:0] want_seq;
      want_seq = 16'b1111_1000_1000_1000;  // f53 for abcd = 0000 first
      for (int i = 0; i < 16; i++) begin
         drive(4'(i));
         #1;
         if ({f53_s, f53_g} !== {2{model_oai(4'(i))}} || f53_s !== want_seq[15 - i]) begin
            failures++;
            $display("FAIL sweep abcd=%b: got %b%b want %b", 4'(i), f53_s, f53_g, want_seq[15 - i]);
         end
         checks++;
         #9;
      end
   endtask

   task automatic test_registered();
      rst = 1'b0;
      drive(4'b1010);
      tick();
      if ({f53_q_s, f53_q_g} !== 2'b00) begin
         failures++;
         $display("FAIL reg_1010: got %b%b want 00", f53_q_s, f53_q_g);
      end
      checks++;
      drive(4'b1100);
      tick();
      if ({f53_q_s, f53_q_g} !== 2'b11) begin
         failures++;
         $display("FAIL reg_1100: got %b%b want 11", f53_q_s, f53_q_g);
      end
      checks++;
   endtask

   task automatic test_selfcheck();
      for (int i = 0; i < 16; i++) begin
         drive(4'(i));
         tick();
         if ({chk_err_s, chk_err_g} !== 2'b00 || f53_q_s !== model_oai(4'(i))) begin
            failures++;
            $display("FAIL selfcheck abcd=%b: chk_err=%b%b f53_q=%b want 00/%b",
                     4'(i), chk_err_s, chk_err_g, f53_q_s, model_oai(4'(i)));
         end
         checks++;
      end
   endtask

   // random back-to-back vectors; f53_q must lag f53 by exactly one edge
   task automatic test_random();
      logic [3:0] code;
      logic       prev_exp;
      prev_exp = f53_q_s;
      for (int i = 0; i < 200; i++) begin
         code = 4'($urandom_range(0, 15));
         drive(code);
         #2;
         if ({f53_s, f53_g} !== {2{model_oai(code)}}) begin
            failures++;
            $display("FAIL rand_f53 abcd=%b: got %b%b want %b", code, f53_s, f53_g, model_oai(code));
         end
         checks++;
         if ({f53_q_s, f53_q_g} !== {2{prev_exp}}) begin
            failures++;
            $display("FAIL rand_f53_q_pre abcd=%b: got %b%b want %b", code, f53_q_s, f53_q_g, prev_exp);
         end
         checks++;
         #3 clk = 1'b1;
         #1;
         prev_exp = model_oai(code);
         if ({f53_q_s, f53_q_g, chk_err_s, chk_err_g} !== {prev_exp, prev_exp, 2'b00}) begin
            failures++;
            $display("FAIL rand_capture abcd=%b: f53_q=%b%b chk_err=%b%b want %b/00",
                     code, f53_q_s, f53_q_g, chk_err_s, chk_err_g, prev_exp);
         end
         checks++;
         #4 clk = 1'b0;
      end
   endtask

   task automatic test_async_reset();
      drive(4'b1111);
      tick();
      if ({f53_q_s, f53_q_g} !== 2'b00) begin
         failures++;
         $display("FAIL async_pre: got %b%b want 00", f53_q_s, f53_q_g);
      end
      checks++;
      #2 rst = 1'b1;
      #1;
      if ({f53_q_s, f53_q_g, f53_s, f53_g} !== 4'b1100) begin
         failures++;
         $display("FAIL async_assert: f53_q=%b%b f53=%b%b want 11/00", f53_q_s, f53_q_g, f53_s, f53_g);
      end
      checks++;
      drive(4'b0101);
      #1;
      if ({f53_s, f53_g} !== 2'b00) begin
         failures++;
         $display("FAIL async_track: got %b%b want 00", f53_s, f53_g);
      end
      checks++;
      #1 rst = 1'b0;
      #1;
      if ({f53_q_s, f53_q_g} !== 2'b11) begin
         failures++;
         $display("FAIL async_release: got %b%b want 11", f53_q_s, f53_q_g);
      end
      checks++;
      tick();
      if ({f53_q_s, f53_q_g} !== 2'b00) begin
         failures++;
         $display("FAIL async_capture: got %b%b want 00", f53_q_s, f53_q_g);
      end
      checks++;
   endtask

   // only meaningful on a 4-state simulator; a 2-state build cannot hold x
   task automatic test_x();
      logic probe;
      logic err_before;
      probe = 1'bx;
      if ($isunknown(probe)) begin
         a = 1'b0; b = 1'b0; c = 1'bx; d = 1'b1;
         #1;
         if ({f53_s, f53_g} !== 2'b11) begin
            failures++;
            $display("FAIL x_forced: got %b%b want 11", f53_s, f53_g);
         end
         checks++;
         a = 1'b1; b = 1'b0; c = 1'bx; d = 1'b0;
         #1;
         if (f53_s !== 1'bx || f53_g !== 1'bx) begin
            failures++;
            $display("FAIL x_unknown: got %b%b want xx", f53_s, f53_g);
         end
         checks++;
         err_before = chk_err_s;
         tick();
         if (chk_err_s !== err_before || chk_err_g !== 1'b0) begin
            failures++;
            $display("FAIL x_chk_err: got %b%b want %b0", chk_err_s, chk_err_g, err_before);
         end
         checks++;
      end
   endtask

   initial begin
      clk = 1'b0;
      rst = 1'b1;
      drive(4'b0000);
      test_reset();
      test_sweep();
      test_registered();
      test_selfcheck();
      test_random();
      test_async_reset();
      test_x();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_cmos_oai
